// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector: runtime-loadable pattern, overlap control,
// Mealy and registered Moore match outputs, and a saturating hit counter.
module seq_detector_param #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic             cfg_overlap,
  input  logic             clr_cnt,
  output logic             out_bit,
  output logic             match_q,
  output logic [CNT_W-1:0] hit_cnt,
  output logic             cnt_sat
);

  localparam int FILL_W = (PAT_W > 2) ? $clog2(PAT_W) : 1;
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_W - 1);

  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_FILLING = 2'd1;
  localparam logic [1:0] ST_ARMED   = 2'd2;

  // Only the newest PAT_W-1 bits need storing; the incoming bit completes the window.
  logic [PAT_W-2:0] hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic             ovl_q, ovl_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             match_d;

  logic [1:0]       state;
  logic [PAT_W-1:0] window;
  logic             hit;

  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no latch is inferred.
    state   = ST_FILLING;
    window  = {hist_q, in_bit};
    hit     = 1'b0;
    hist_d  = hist_q;
    fill_d  = fill_q;
    pat_d   = pat_q;
    ovl_d   = ovl_q;
    cnt_d   = cnt_q;

    if (fill_q == '0) begin
      state = ST_EMPTY;
    end else if (fill_q == FILL_LAST) begin
      state = ST_ARMED;
    end

    hit = in_valid && !cfg_load && (state == ST_ARMED) && (window == pat_q);

    if (cfg_load) begin
      // A reconfiguration drops any bit presented in the same cycle.
      pat_d  = cfg_pattern;
      ovl_d  = cfg_overlap;
      hist_d = '0;
      fill_d = '0;
    end else if (in_valid) begin
      hist_d = window[PAT_W-2:0];
      case (state)
        ST_ARMED: begin
          if (hit && !ovl_q) begin
            fill_d = '0;
          end
        end
        default: fill_d = fill_q + FILL_W'(1);
      endcase
    end

    if (clr_cnt) begin
      cnt_d = '0;
    end else if (hit && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    match_d = hit;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q  <= '0;
      fill_q  <= '0;
      pat_q   <= '0;
      ovl_q   <= 1'b1;
      cnt_q   <= '0;
      match_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      pat_q   <= pat_d;
      ovl_q   <= ovl_d;
      cnt_q   <= cnt_d;
      match_q <= match_d;
    end
  end

  assign out_bit = hit;
  assign hit_cnt = cnt_q;
  assign cnt_sat = &cnt_q;

endmodule
